// File: rtl/cla_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cla_adder_pipe                                                  |
// | Function : Pipelined carry-lookahead adder with valid/ready on both sides; |
// |            define CLA_SUB_EN to add a per-beat subtract control (in_sub).  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cla_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CLA_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int c_slice = WIDTH / STAGES;
    localparam int c_ngrp  = c_slice / GROUP;

    if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_cfg
        $error("cla_adder_pipe: WIDTH must be a multiple of STAGES*GROUP");
    end

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [c_slice+1:0] slice_add(
        input logic [c_slice-1:0] a,
        input logic [c_slice-1:0] b,
        input logic               cin
    );
        logic [c_slice-1:0] g;
        logic [c_slice-1:0] p;
        logic [c_slice:0]   c;
        logic [c_ngrp:0]    cg;
        logic               gg;
        logic               pp;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        cg    = '0;
        cg[0] = cin;
        for (int j = 0; j < c_ngrp; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                c[j*GROUP+i] = gg | (pp & cg[j]);
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                pp = pp & p[j*GROUP+i];
            end
            cg[j+1] = gg | (pp & cg[j]);
        end
        c[c_slice] = cg[c_ngrp];
        return {c[c_slice-1], c[c_slice], p ^ c[c_slice-1:0]};
    endfunction

    logic             w_sub;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;

`ifdef CLA_SUB_EN
    assign w_sub = in_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtract is folded into the operands at capture, so it travels with the beat.
    assign w_b_in   = w_sub ? ~in_b : in_b;
    assign w_cin_in = w_sub | in_cin;

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] ovf_q;

    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] ovf_d;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]   w_src_a;
        logic [WIDTH-1:0]   w_src_b;
        logic [WIDTH-1:0]   w_src_sum;
        logic               w_src_c;
        logic [c_slice+1:0] w_res;
        logic [WIDTH-1:0]   w_sum;

        if (k == 0) begin : g_head
            assign w_src_a   = in_a;
            assign w_src_b   = w_b_in;
            assign w_src_sum = '0;
            assign w_src_c   = w_cin_in;
            assign w_vin[k]  = in_valid;
        end else begin : g_body
            assign w_src_a   = a_q[k-1];
            assign w_src_b   = b_q[k-1];
            assign w_src_sum = sum_q[k-1];
            assign w_src_c   = carry_q[k-1];
            assign w_vin[k]  = valid_q[k-1];
        end

        assign w_res = slice_add(w_src_a[k*c_slice +: c_slice],
                                 w_src_b[k*c_slice +: c_slice], w_src_c);

        always_comb begin
            w_sum = w_src_sum;
            w_sum[k*c_slice +: c_slice] = w_res[c_slice-1:0];
        end

        // A stage may load when empty or when everything downstream can move.
        assign w_ready[k]  = out_ready | ~(&valid_q[STAGES-1:k]);
        assign a_d[k]      = w_src_a;
        assign b_d[k]      = w_src_b;
        assign sum_d[k]    = w_sum;
        assign carry_d[k]  = w_res[c_slice];
        assign ovf_d[k]    = w_res[c_slice+1] ^ w_res[c_slice];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    valid_q[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        a_q[k]     <= a_d[k];
                        b_q[k]     <= b_d[k];
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= carry_d[k];
                        ovf_q[k]   <= ovf_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cla_adder_pipe                                               |
// | Function : Self-checking bench for cla_adder_pipe against an integer model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cla_adder_pipe;

    localparam int WIDTH  = 16;
    localparam int GROUP  = 4;
    localparam int STAGES = 4;

    typedef logic [WIDTH+1:0] res_t;   // {ovf, cout, sum}

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q[$];

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic             ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    task automatic randomize_inputs();
        in_a   = WIDTH'($urandom);
        in_b   = WIDTH'($urandom);
        in_cin = 1'($urandom);
`ifdef CLA_SUB_EN
        in_sub = 1'($urandom);
`endif
    endtask

    // Sample mid-cycle, then advance to 1 time unit past the next rising edge.
    task automatic cycle(output logic acc, output logic emit, output logic ov, output res_t obs);
        @(negedge clk);
        acc  = in_valid & in_ready;
        emit = out_valid & out_ready;
        ov   = out_valid;
        obs  = {out_ovf, out_cout, out_sum};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hold: valid/ready=%b expected 01", {out_valid, in_ready});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out_ovf, out_cout, out_sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ovf/cout/sum=%b/%b/%h expected 0/0/0000",
                     out_ovf, out_cout, out_sum);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        res_t        ve [4];
        logic acc, emit, ov, got;
        res_t obs;
        int   lat;
        va = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
        vb = '{16'h0001, 16'h0001, 16'h8000, 16'h0FFF};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1};
        ve = '{{2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b11, 16'h0000}, {2'b00, 16'h2234}};
        out_ready = 1'b1;
        in_sub    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            in_cin   = vc[i];
            cycle(acc, emit, ov, obs);
            in_valid = 1'b0;
            n_checks++;
            if (acc !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_accept[%0d]: accepted=%b expected 1", i, acc);
            end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                cycle(acc, emit, ov, obs);
                lat++;
                got = emit;
            end
            n_checks++;
            if (!got || lat != STAGES) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (seen=%b) expected %0d",
                         i, lat, got, STAGES);
            end
            n_checks++;
            if (obs !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: ovf/cout/sum=%b/%b/%h expected %b/%b/%h",
                         i, obs[WIDTH+1], obs[WIDTH], obs[WIDTH-1:0],
                         ve[i][WIDTH+1], ve[i][WIDTH], ve[i][WIDTH-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc, emit, ov;
        res_t obs, exp;
        int   sent = 0, n_emit = 0, first = -1, last = -1, notready = 0, cyc = 0;
        q.delete();
        out_ready = 1'b1;
        while (n_emit < 64 && cyc < 200) begin
            if (sent < 64) begin
                in_valid = 1'b1;
                randomize_inputs();
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc, emit, ov, obs);
            if (emit) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious: result %h with nothing outstanding", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got %h expected %h", n_emit, obs, exp);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n_emit++;
            end
            if (acc) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub));
                sent++;
            end else if (in_valid) begin
                notready++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_emit != 64 || last - first != 63) begin
            n_fail++;
            $display("FAIL b2b_throughput: %0d results over span %0d expected 64 over 63",
                     n_emit, last - first);
        end
        n_checks++;
        if (notready != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: %0d stalled cycles expected 0", notready);
        end
    endtask

    task automatic test_backpressure();
        logic acc, emit, ov, prev_stall;
        res_t obs, exp, hold, prev_obs;
        int   accepted = 0, extra = 0, cyc = 0, spurious = 0;
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            randomize_inputs();
            cycle(acc, emit, ov, obs);
            if (acc) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub));
                accepted++;
            end
        end
        n_checks++;
        if (accepted != STAGES || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_fill: accepted %0d in_ready=%b expected %0d and 0",
                     accepted, in_ready, STAGES);
        end
        hold = {out_ovf, out_cout, out_sum};
        n_checks++;
        if (q.size() == 0 || hold !== q[0]) begin
            n_fail++;
            $display("FAIL bp_head: got %h expected oldest beat %h", hold,
                     (q.size() != 0) ? q[0] : res_t'(0));
        end
        for (int i = 0; i < 5; i++) begin
            cycle(acc, emit, ov, obs);
            n_checks++;
            if (acc !== 1'b0 || ov !== 1'b1 || obs !== hold) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: acc=%b valid=%b out=%h expected 0/1/%h",
                         i, acc, ov, obs, hold);
            end
        end
        prev_stall = 1'b0;
        prev_obs   = '0;
        while ((q.size() != 0 || extra < 20) && cyc < 400) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (extra < 20) ? 1'($urandom) : 1'b0;
            randomize_inputs();
            cycle(acc, emit, ov, obs);
            if (prev_stall) begin
                n_checks++;
                if (ov !== 1'b1 || obs !== prev_obs) begin
                    n_fail++;
                    $display("FAIL bp_stall_stable: valid=%b out=%h expected 1/%h", ov, obs, prev_obs);
                end
            end
            prev_stall = ov & ~out_ready;
            prev_obs   = obs;
            if (emit) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_duplicate: result %h with nothing outstanding", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL bp_drain: got %h expected %h", obs, exp);
                    end
                end
            end
            if (acc) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub));
                extra++;
            end
            cyc++;
        end
        n_checks++;
        if (q.size() != 0 || extra != 20) begin
            n_fail++;
            $display("FAIL bp_lost: %0d outstanding, %0d extra accepted expected 0 and 20",
                     q.size(), extra);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(acc, emit, ov, obs);
            if (emit) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL bp_idle: %0d results after drain expected 0", spurious);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, emit, ov;
        res_t obs;
        int   stale = 0;
        q.delete();
        out_ready = 1'b1;
        in_sub    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            randomize_inputs();
            in_sub = 1'b0;
            cycle(acc, emit, ov, obs);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: valid=%b ready=%b sum=%h expected 0/1/0000",
                     out_valid, in_ready, out_sum);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(acc, emit, ov, obs);
            if (ov) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midrst_stale: %0d cycles with out_valid expected 0", stale);
        end
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub();
        logic acc, emit, ov;
        res_t obs;
        int   lat = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sub    = 1'b1;
        in_a      = 16'h0005;
        in_b      = 16'h0007;
        in_cin    = 1'b0;
        cycle(acc, emit, ov, obs);
        in_valid = 1'b0;
        in_sub   = 1'b0;
        emit     = 1'b0;
        while (!emit && lat < 20) begin
            cycle(acc, emit, ov, obs);
            lat++;
        end
        n_checks++;
        if (!emit || obs !== {2'b00, 16'hFFFE}) begin
            n_fail++;
            $display("FAIL sub_5_minus_7: seen=%b out=%h expected ovf/cout/sum 0/0/fffe", emit, obs);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
